// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external WIDTH-bit adder among NUM_REQ requesters.
// Define ADDER_SHARE_B2B_EN to allow a new grant in the same cycle a response is accepted.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 32,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  input  logic [NUM_REQ-1:0]       i_req_cin,
  output logic [WIDTH-1:0]         o_add_a,
  output logic [WIDTH-1:0]         o_add_b,
  output logic                     o_add_cin,
  input  logic [WIDTH:0]           i_add_result,
  input  logic                     i_add_overflow,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [IW-1:0]            o_rsp_id,
  output logic [WIDTH:0]           o_rsp_result,
  output logic                     o_rsp_overflow
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`ifdef ADDER_SHARE_B2B_EN
  localparam logic B2B = 1'b1;
`else
  localparam logic B2B = 1'b0;
`endif
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_gnt, w_ptr_nxt, w_base, w_sel;
  logic [WIDTH-1:0] r_add_a, r_add_b, w_a, w_b;
  logic r_add_cin, w_cin, w_any, w_hs, w_take;
  logic r_rsp_valid, r_rsp_overflow;
  logic [IW-1:0] r_rsp_id;
  logic [WIDTH:0] r_rsp_result;
  int w_idx;
  assign w_hs = (r_state == RESP) && r_rsp_valid && i_rsp_ready;
  assign w_ptr_nxt = (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
  // In RESP the arbiter looks ahead to the pointer the handshake is about to install
  assign w_base = (r_state == RESP) ? w_ptr_nxt : r_ptr;
  assign w_take = w_any && ((r_state == IDLE) || (B2B && w_hs));
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_a = '0;
    w_b = '0;
    w_cin = 1'b0;
    w_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(w_base) + k) % NUM_REQ;
      if (i_req_valid[w_idx]) begin
        w_any = 1'b1;
        w_sel = IW'(w_idx);
        w_a = i_req_a[w_idx*WIDTH +: WIDTH];
        w_b = i_req_b[w_idx*WIDTH +: WIDTH];
        w_cin = i_req_cin[w_idx];
      end
    end
  end
  always_comb begin
    w_next = r_state;
    w_next = w_take ? EXEC : (r_state == EXEC) ? RESP : (w_hs || r_state == IDLE) ? IDLE : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_gnt <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
      r_add_cin <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id <= '0;
      r_rsp_result <= '0;
      r_rsp_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_add_a <= w_a;
        r_add_b <= w_b;
        r_add_cin <= w_cin;
        r_gnt <= w_sel;
      end
      if (r_state == EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id <= r_gnt;
        r_rsp_result <= i_add_result;
        r_rsp_overflow <= i_add_overflow;
      end else if (w_hs) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_hs) r_ptr <= w_ptr_nxt;
    end
  end
  assign o_req_ready = w_take ? (NUM_REQ'(1) << w_sel) : '0;
  assign o_add_a = r_add_a;
  assign o_add_b = r_add_b;
  assign o_add_cin = r_add_cin;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_overflow = r_rsp_overflow;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: random and directed stimulus against a transaction-level model of the arbiter.
module tb_adder_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int IW = 2;
`ifdef ADDER_SHARE_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_cin = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0] add_a, add_b;
  logic add_cin, add_ovf, rsp_valid, rsp_ovf;
  logic rsp_ready = 1'b0;
  logic [W:0] add_result, rsp_result;
  logic [IW-1:0] rsp_id;
  always #5 clk = ~clk;
  // The shared adder that normally lives outside the arbiter
  assign add_result = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_ovf = (add_a[W-1] == add_b[W-1]) && (add_result[W-1] != add_a[W-1]);
  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_cin(req_cin),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_result(add_result), .i_add_overflow(add_ovf),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_rsp_overflow(rsp_ovf));
  typedef struct {int id; logic [W:0] res; logic ovf;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int m_ptr = 0, m_gnt = 0, age = 0;
  bit busy = 1'b0;
  logic [W-1:0] op_a[N], op_b[N];
  logic op_c[N];
  logic [W:0] last_res = '0;
  logic last_ovf = 1'b0;
  int last_id = -1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    longint s, u;
    u = longint'({32'd0, a}) + longint'({32'd0, b}) + longint'(c);
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    e.id = id;
    e.res = u[W:0];
    e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return e;
  endfunction
  task automatic new_ops(input int i);
    int sel;
    sel = int'($urandom_range(0, 5));
    op_a[i] = (sel == 0) ? 32'h7FFF_FFFF : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'h8000_0000 : $urandom;
    op_b[i] = (sel == 3) ? 32'h1 : $urandom;
    op_c[i] = 1'($urandom_range(0, 1));
  endtask
  task automatic step(input logic [N-1:0] v, input bit rdy);
    bit hs;
    logic [N-1:0] exp_r;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_cin[i] = op_c[i];
    end
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(busy && age >= 2));
    hs = busy && age >= 2 && rdy;
    if (hs) begin
      busy = 1'b0;
      m_ptr = (m_gnt + 1) % N;
    end
    exp_r = '0;
    if (!busy && (!hs || B2B) && v != 0) begin
      for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
      exp_r[m_gnt] = 1'b1;
      busy = 1'b1;
      age = 0;
      q.push_back(model(m_gnt, op_a[m_gnt], op_b[m_gnt], op_c[m_gnt]));
      new_ops(m_gnt);
    end
    chk("req_ready", 64'(req_ready), 64'(exp_r));
    age++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    q.delete();
    busy = 1'b0;
    m_ptr = 0;
    age = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // Monitor: response content must match the oldest outstanding expectation while valid
  always @(negedge clk) begin
    #2;
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got response id %0d expected none", rsp_id);
      end else begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
        chk("rsp_overflow", 64'(rsp_ovf), 64'(q[0].ovf));
        if (rsp_ready) begin
          last_res = rsp_result;
          last_ovf = rsp_ovf;
          last_id = int'(rsp_id);
          void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < N; i++) new_ops(i);
    do_reset();
    #1;
    chk("reset_add_a", 64'(add_a), 64'd0);
    chk("reset_add_b", 64'(add_b), 64'd0);
    chk("reset_add_cin", 64'(add_cin), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_rsp_overflow", 64'(rsp_ovf), 64'd0);
    op_a[0] = 32'h5; op_b[0] = 32'h3; op_c[0] = 1'b1;
    step(4'b0001, 1'b1);
    repeat (3) step(4'b0000, 1'b1);
    chk("single_result", 64'(last_res), 64'h0_0000_0009);
    chk("single_ovf", 64'(last_ovf), 64'd0);
    chk("single_id", 64'(last_id), 64'd0);
    op_a[1] = 32'h7FFF_FFFF; op_b[1] = 32'h1; op_c[1] = 1'b0;
    step(4'b0010, 1'b1);
    repeat (3) step(4'b0000, 1'b1);
    chk("pos_ovf_result", 64'(last_res), 64'h0_8000_0000);
    chk("pos_ovf_flag", 64'(last_ovf), 64'd1);
    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h1; op_c[2] = 1'b0;
    step(4'b0100, 1'b1);
    repeat (3) step(4'b0000, 1'b1);
    chk("carry_result", 64'(last_res), 64'h1_0000_0000);
    chk("carry_ovf", 64'(last_ovf), 64'd0);
    repeat (20) step(4'b1111, 1'b1);
    repeat (3) step(4'b1111, 1'b1);
    repeat (8) step(4'b1111, 1'b0);
    repeat (6) step(4'b1111, 1'b1);
    step(4'b1000, 1'b1);
    do_reset();
    step(4'b0110, 1'b1);
    chk("reset_mid_grant", 64'(req_ready), 64'b0010);
    repeat (4) step(4'b0000, 1'b1);
    repeat (12) step(4'b0011, 1'b1);
    for (int c = 0; c < 400; c++) step(N'($urandom), $urandom_range(0, 9) < 7);
    repeat (6) step(4'b0000, 1'b1);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
